// File: rtl/smpl_dump.sv
// Drains one channel's circular capture RAM to the UART, oldest byte first,
// using a registered read and a trmt/tx_done handshake per byte.
module smpl_dump #(
  parameter int ENTRIES = 384,
  parameter int ADDR_W  = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dump_start,
  input  logic              dump_abort,
  input  logic [ADDR_W-1:0] start_addr,
  output logic              ram_en,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [7:0]        ram_rdata,
  output logic [7:0]        tx_data,
  output logic              trmt,
  input  logic              tx_done,
  output logic              busy,
  output logic              dump_done,
  output logic              aborted
);

  typedef enum logic [2:0] {IDLE, RD, LAT, SEND, WTX, FIN} state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(ENTRIES - 1);

  state_t            state_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [ADDR_W-1:0] cnt_q;
  logic [7:0]        tx_data_q;
  logic              ram_en_q;
  logic              trmt_q;
  logic              busy_q;
  logic              done_q;
  logic              aborted_q;

  logic [ADDR_W-1:0] addr_d;
  logic [ADDR_W-1:0] start_d;

  assign addr_d  = (ram_addr_q == LAST) ? '0 : ram_addr_q + ADDR_W'(1);
  assign start_d = (start_addr > LAST) ? '0 : start_addr;

  // Pulse outputs are set on the edge entering their state, so RD with an
  // abort already pending at entry never issues a read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ram_addr_q <= '0;
      cnt_q      <= '0;
      tx_data_q  <= '0;
      ram_en_q   <= 1'b0;
      trmt_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      aborted_q  <= 1'b0;
    end else begin
      ram_en_q <= 1'b0;
      trmt_q   <= 1'b0;
      done_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (dump_start) begin
            ram_addr_q <= start_d;
            cnt_q      <= '0;
            busy_q     <= 1'b1;
            aborted_q  <= 1'b0;
            ram_en_q   <= !dump_abort;
            state_q    <= RD;
          end
        end
        RD: begin
          if (dump_abort || !ram_en_q) begin
            aborted_q <= 1'b1;
            done_q    <= 1'b1;
            state_q   <= FIN;
          end else begin
            state_q <= LAT;
          end
        end
        LAT: begin
          tx_data_q <= ram_rdata;
          trmt_q    <= 1'b1;
          state_q   <= SEND;
        end
        SEND: state_q <= WTX;
        WTX: begin
          if (tx_done) begin
            if (dump_abort) begin
              aborted_q <= 1'b1;
              done_q    <= 1'b1;
              state_q   <= FIN;
            end else if (cnt_q == LAST) begin
              done_q  <= 1'b1;
              state_q <= FIN;
            end else begin
              cnt_q      <= cnt_q + ADDR_W'(1);
              ram_addr_q <= addr_d;
              ram_en_q   <= 1'b1;
              state_q    <= RD;
            end
          end
        end
        FIN: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ram_en    = ram_en_q;
  assign ram_addr  = ram_addr_q;
  assign tx_data   = tx_data_q;
  assign trmt      = trmt_q;
  assign busy      = busy_q;
  assign dump_done = done_q;
  assign aborted   = aborted_q;

endmodule

// File: tb/tb_smpl_dump.sv
// Directed bench for smpl_dump: RAM and UART models plus a negedge monitor.
module tb_smpl_dump;
  localparam int ENTRIES = 384;
  localparam int ADDR_W  = 9;

  logic              clk = 1'b0;
  logic              rst;
  logic              dump_start;
  logic              dump_abort;
  logic [ADDR_W-1:0] start_addr;
  logic              ram_en;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_rdata;
  logic [7:0]        tx_data;
  logic              trmt;
  logic              tx_done;
  logic              busy;
  logic              dump_done;
  logic              aborted;

  logic [7:0]  mem [ENTRIES];
  logic        uart_done;
  logic        spur;
  int          uart_cnt;
  int          tx_delay;
  int          cyc;
  int          checks;
  int          failures;
  int          done_n;
  int          oob;
  logic [7:0]        sent [$];
  logic [ADDR_W-1:0] rd_addr [$];
  int                trmt_cyc [$];
  int                done_cyc [$];

  smpl_dump #(.ENTRIES(ENTRIES), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .dump_start(dump_start), .dump_abort(dump_abort),
    .start_addr(start_addr), .ram_en(ram_en), .ram_addr(ram_addr),
    .ram_rdata(ram_rdata), .tx_data(tx_data), .trmt(trmt), .tx_done(tx_done),
    .busy(busy), .dump_done(dump_done), .aborted(aborted)
  );

  always #5 clk = ~clk;

  assign tx_done = uart_done | spur;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ram_en) ram_rdata <= mem[ram_addr];
  end

  // UART model: one tx_done pulse tx_delay clocks after each trmt
  always @(posedge clk) begin
    if (rst) begin
      uart_cnt  <= 0;
      uart_done <= 1'b0;
    end else begin
      uart_done <= (uart_cnt == 1);
      if (trmt) uart_cnt <= tx_delay;
      else if (uart_cnt != 0) uart_cnt <= uart_cnt - 1;
    end
  end

  always @(negedge clk) begin
    if (trmt) begin
      sent.push_back(tx_data);
      trmt_cyc.push_back(cyc);
    end
    if (uart_done) done_cyc.push_back(cyc);
    if (ram_en) rd_addr.push_back(ram_addr);
    if (ram_addr >= ADDR_W'(ENTRIES)) oob++;
    if (dump_done) done_n++;
  end

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic clr();
    sent.delete(); rd_addr.delete(); trmt_cyc.delete(); done_cyc.delete();
    done_n = 0; oob = 0;
  endtask

  task automatic start(input int a);
    @(negedge clk);
    start_addr = ADDR_W'(a);
    dump_start = 1'b1;
    @(negedge clk);
    dump_start = 1'b0;
  endtask

  task automatic wait_sent(input string tag, input int n);
    int k = 0;
    while (sent.size() < n && k < 50000) begin @(negedge clk); k++; end
    chk(tag, (k >= 50000), 0);
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    while (done_n == 0 && k < 20000) begin @(negedge clk); k++; end
    chk(tag, (k >= 20000), 0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int err;
    cyc = 0; checks = 0; failures = 0; done_n = 0; oob = 0;
    rst = 1'b1; dump_start = 1'b0; dump_abort = 1'b0; start_addr = '0;
    spur = 1'b0; tx_delay = 20;
    for (int i = 0; i < ENTRIES; i++) mem[i] = i[7:0];
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_trmt", trmt, 0);
    chk("rst_ram_en", ram_en, 0);
    chk("rst_addr", ram_addr, 0);
    chk("rst_txdata", tx_data, 0);
    chk("rst_done", dump_done, 0);
    chk("rst_aborted", aborted, 0);
    rst = 1'b0;

    // reset mid-dump while byte 5 is in flight
    clr();
    start(0);
    wait_sent("mid_rst_wait", 5);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_trmt", trmt, 0);
    chk("mid_rst_ram_en", ram_en, 0);
    @(negedge clk);
    rst = 1'b0;

    // full dump from address 0
    clr();
    start(0);
    wait_done("full_tmo");
    chk("full_first_addr", rd_addr[0], 0);
    chk("full_count", sent.size(), ENTRIES);
    err = 0;
    for (int i = 0; i < sent.size(); i++) if (sent[i] !== i[7:0]) err++;
    chk("full_seq_err", err, 0);
    chk("full_done_n", done_n, 1);
    chk("full_busy", busy, 0);
    chk("full_aborted", aborted, 0);

    // wrap-around from 380
    clr();
    start(380);
    wait_done("wrap_tmo");
    chk("wrap_rd0", rd_addr[0], 380);
    chk("wrap_rd3", rd_addr[3], 383);
    chk("wrap_rd4", rd_addr[4], 0);
    chk("wrap_rdlast", rd_addr[ENTRIES-1], 379);
    chk("wrap_count", sent.size(), ENTRIES);
    err = 0;
    for (int i = 0; i < sent.size(); i++) if (sent[i] !== 8'((380 + i) % ENTRIES)) err++;
    chk("wrap_seq_err", err, 0);
    chk("wrap_oob", oob, 0);

    // slow UART with a spurious tx_done during LAT, then abort
    clr();
    tx_delay = 1000;
    start(0);
    do @(negedge clk); while (!uart_done);
    @(negedge clk);
    @(negedge clk);
    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    wait_sent("hs_wait", 4);
    @(negedge clk);
    dump_abort = 1'b1;
    wait_done("hs_tmo");
    dump_abort = 1'b0;
    chk("hs_count", sent.size(), 4);
    chk("hs_txdone_n", done_cyc.size(), 4);
    err = 0;
    for (int i = 1; i < trmt_cyc.size(); i++) if (trmt_cyc[i] - done_cyc[i-1] != 3) err++;
    chk("hs_latency_err", err, 0);
    chk("hs_aborted", aborted, 1);

    // abort during WTX of byte 10
    clr();
    tx_delay = 20;
    start(0);
    wait_sent("ab_wait", 11);
    @(negedge clk);
    dump_abort = 1'b1;
    wait_done("ab_tmo");
    dump_abort = 1'b0;
    repeat (30) @(negedge clk);
    chk("ab_count", sent.size(), 11);
    chk("ab_last_byte", sent[10], 10);
    chk("ab_done_n", done_n, 1);
    chk("ab_aborted", aborted, 1);
    chk("ab_busy", busy, 0);

    // new start clears aborted; start_addr 500 clamps to 0
    clr();
    start(500);
    chk("clr_aborted", aborted, 0);
    chk("clr_busy", busy, 1);
    wait_sent("clamp_wait", 1);
    chk("clamp_addr", rd_addr[0], 0);
    @(negedge clk);
    dump_abort = 1'b1;
    wait_done("clamp_tmo");
    dump_abort = 1'b0;

    // dump_start while busy is ignored
    clr();
    tx_delay = 2;
    start(0);
    wait_sent("busy_wait", 50);
    start(7);
    wait_done("busy_tmo");
    repeat (20) @(negedge clk);
    chk("busy_count", sent.size(), ENTRIES);
    err = 0;
    for (int i = 0; i < sent.size(); i++) if (sent[i] !== i[7:0]) err++;
    chk("busy_seq_err", err, 0);
    chk("busy_done_n", done_n, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
